// File: rtl/bitrev_frame_sequencer.sv
// Double-buffered bit-reversal sequencer: natural-order samples in, bit-reversed frames out.
// One bank fills while the other drains; only the per-bank full flag is stored.
module bitrev_frame_sequencer #(
    parameter int unsigned SAMPLES = 8,
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [7:0]        frame_count
);

    if (SAMPLES != (1 << WIDTH)) begin : g_bad_params
        $error("bitrev_frame_sequencer: SAMPLES must equal 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LastIdx = WIDTH'(SAMPLES - 1);

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] idx);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) begin
            r[k] = idx[WIDTH-1-k];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem_q [2][SAMPLES];

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic [7:0]       frame_count_q, frame_count_d;

    logic wr_fire, wr_done, rd_fire, rd_done;

    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        out_data  = out_valid ? mem_q[rd_bank_q][rd_cnt_q] : '0;
        out_last  = out_valid && (rd_cnt_q == LastIdx);

        wr_fire = in_valid && in_ready;
        wr_done = wr_fire && (wr_cnt_q == LastIdx);
        rd_fire = out_valid && out_ready;
        rd_done = rd_fire && out_last;
    end

    // Counters wrap to zero on their own at the frame boundary.
    always_comb begin
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        full_d        = full_q;
        frame_count_d = frame_count_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_count_d     = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            full_q        <= 2'b00;
            frame_count_q <= 8'd0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            full_q        <= full_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
        end
    end

    // Filling needs the flag clear, draining needs it set, so both can never hit one bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_done && rd_done && (wr_bank_q == rd_bank_q)))
            else $error("bitrev_frame_sequencer: set and clear of one full flag together");
        end
    end

    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bitrev_frame_sequencer.sv
// Bench for bitrev_frame_sequencer: frame-level reference model (queues of completed frames)
// driven by directed and random stimulus.
module tb_bitrev_frame_sequencer;

    localparam int unsigned SAMPLES = 8;
    localparam int unsigned WIDTH   = 3;
    localparam int unsigned DATA_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic [7:0]        frame_count;

    bitrev_frame_sequencer #(
        .SAMPLES (SAMPLES),
        .WIDTH   (WIDTH),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
    } exp_t;

    // Reference model state
    logic [DATA_W-1:0] cur_q [$];
    exp_t              exp_q [$];
    logic [DATA_W-1:0] got_q [$];
    int                pending;
    int                drained;
    int                fc_model;

    int n_assert = 0;
    int n_fail   = 0;
    bit acc;
    int cyc;
    int first_vcyc;
    int sent;
    int d0;

    function automatic int rev_index(input int i);
        int r = 0;
        for (int b = 0; b < WIDTH; b++) begin
            r = r * 2 + ((i >> b) & 1);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        cur_q.delete();
        exp_q.delete();
        pending  = 0;
        fc_model = 0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        logic              e_ir, e_ov, e_l;
        logic [DATA_W-1:0] e_d;
        bit                in_hs, out_hs;
        @(negedge clk);
        e_ir = (pending < 2);
        e_ov = (pending > 0);
        e_d  = e_ov ? exp_q[0].data : '0;
        e_l  = e_ov ? exp_q[0].last : 1'b0;
        check("in_ready", 32'(in_ready), 32'(e_ir));
        check("out_valid", 32'(out_valid), 32'(e_ov));
        check("out_data", 32'(out_data), 32'(e_d));
        check("out_last", 32'(out_last), 32'(e_l));
        check("frame_count", 32'(frame_count), 32'(fc_model & 255));
        if (out_valid === 1'b1 && first_vcyc < 0) first_vcyc = cyc + 1;
        in_hs  = in_valid && e_ir;
        out_hs = e_ov && out_ready;
        if (out_hs) got_q.push_back(out_data);
        @(posedge clk);
        #1;
        if (out_hs) begin
            if (exp_q[0].last) begin
                pending--;
                drained++;
                fc_model++;
            end
            void'(exp_q.pop_front());
        end
        if (in_hs) begin
            cur_q.push_back(in_data);
            if (cur_q.size() == SAMPLES) begin
                for (int k = 0; k < SAMPLES; k++) begin
                    exp_q.push_back('{data: cur_q[rev_index(k)], last: (k == SAMPLES - 1)});
                end
                cur_q.delete();
                pending++;
            end
        end
        acc = in_hs;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Offer nfr frames and run until they have all drained (bounded by a cycle budget).
    task automatic stream(input int nfr, input int pv, input int pr, input bit seq);
        int  target = drained + nfr;
        int  limit  = nfr * SAMPLES * 20 + 100;
        int  nsent  = 0;
        bit  hold   = 0;
        cyc        = 0;
        first_vcyc = -1;
        got_q.delete();
        while (drained < target && cyc < limit) begin
            if (!hold) begin
                in_valid = (nsent < nfr * SAMPLES) && ($urandom_range(99) < pv);
                in_data  = seq ? DATA_W'(nsent) : DATA_W'($urandom);
            end
            out_ready = ($urandom_range(99) < pr);
            step();
            cyc++;
            if (acc) nsent++;
            hold = in_valid && !acc;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_frames_drained", 32'(drained - (target - nfr)), 32'(nfr));
    endtask

    task automatic check_single_frame(input string tag);
        logic [DATA_W-1:0] ref_out [SAMPLES] = '{0, 4, 2, 6, 1, 5, 3, 7};
        check({tag, "_count"}, 32'(got_q.size()), 32'(SAMPLES));
        for (int k = 0; k < SAMPLES && k < got_q.size(); k++) begin
            check({tag, "_order"}, 32'(got_q[k]), 32'(ref_out[k]));
        end
    endtask

    initial begin
        drained = 0;
        model_clear();
        do_reset();
        cyc = 0;
        step();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        // Single frame, ordered data
        stream(1, 100, 100, 1'b1);
        check("single_first_valid_cycle", 32'(first_vcyc), 32'd9);
        check("single_cycles", 32'(cyc), 32'd16);
        check("single_frame_count", 32'(frame_count), 32'd1);
        check_single_frame("single");

        // Four back-to-back frames: no bubbles anywhere
        stream(4, 100, 100, 1'b1);
        check("stream_cycles", 32'(cyc), 32'(SAMPLES * 5));
        check("stream_frame_count", 32'(frame_count), 32'd5);

        // Backpressure: three frames offered with the output stalled
        out_ready = 1'b0;
        sent      = 0;
        d0        = drained;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(sent);
            step();
            if (acc) sent++;
        end
        check("bp_accepted", 32'(sent), 32'd16);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cyc       = 0;
        while ((sent < 24 || pending > 0) && cyc < 200) begin
            in_valid = (sent < 24);
            in_data  = DATA_W'(sent);
            step();
            cyc++;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_frames_drained", 32'(drained - d0), 32'd3);

        // Random handshakes, random data
        stream(50, 60, 50, 1'b0);

        // Reset mid-fill
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(100 + i);
            step();
        end
        do_reset();
        step();
        check("rst_fill_out_valid", 32'(out_valid), 32'd0);
        stream(1, 100, 100, 1'b1);
        check_single_frame("after_fill_reset");

        // Reset mid-drain: full frame in, three samples out
        got_q.delete();
        for (int i = 0; i < SAMPLES; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(200 + i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("pre_reset_drained", 32'(got_q.size()), 32'd3);
        do_reset();
        step();
        check("rst_drain_out_valid", 32'(out_valid), 32'd0);
        check("rst_drain_out_data", 32'(out_data), 32'd0);
        check("rst_drain_out_last", 32'(out_last), 32'd0);
        check("rst_drain_frame_count", 32'(frame_count), 32'd0);
        stream(1, 100, 100, 1'b1);
        check_single_frame("after_drain_reset");

        // frame_count wrap
        do_reset();
        stream(257, 100, 100, 1'b1);
        check("fc_wrap", 32'(frame_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bitrev_frame_sequencer.md
# bitrev_frame_sequencer

Streaming front end for the FFT datapath. Accepts samples one per handshake in natural order, writes each into a ping-pong frame buffer at its bit-reversed index, and streams each completed frame out in buffer order. The output is therefore the bit-reversed permutation of the input frame, which is the order a decimation-in-time FFT butterfly array consumes. It replaces the fully parallel, all-samples-at-once permutation with a sequenced, backpressured, double-buffered one. One frame can fill while the previous frame drains.

## Interface
Parameters:
- SAMPLES, 8, samples per frame; must equal 2**WIDTH (elaboration error otherwise)
- WIDTH, 3, index width in bits (log2 SAMPLES)
- DATA_W, 16, sample width in bits

Ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample present
- in_data  in  DATA_W  input sample, natural order
- in_ready  out  1  sequencer can accept in_data this cycle
- out_valid  out  1  output sample present
- out_data  out  DATA_W  output sample, bit-reversed order
- out_last  out  1  marks the final sample of a frame
- out_ready  in  1  downstream accepts out_data this cycle
- frame_count  out  8  number of frames fully drained, wraps modulo 256

## Operation
Storage:
- Two banks, each holding SAMPLES × DATA_W.
- Per-bank full flag, full[0:1].

Write side:
- State is wr_bank (1 bit) and wr_cnt (WIDTH bits).
- in_ready = !full[wr_bank].
- On in_valid && in_ready: bank[wr_bank][bitrev(wr_cnt)] <= in_data, then wr_cnt++.
- bitrev(i): output bit k = input bit WIDTH-1-k.
- When the accepted sample has wr_cnt == SAMPLES-1: set full[wr_bank], toggle wr_bank, set wr_cnt to 0.

Read side:
- State is rd_bank (1 bit) and rd_cnt (WIDTH bits).
- out_valid = full[rd_bank].
- out_data = bank[rd_bank][rd_cnt] when out_valid, otherwise 0.
- out_last = out_valid && (rd_cnt == SAMPLES-1).
- On out_valid && out_ready: rd_cnt++.
- When that accepted sample has out_last set: clear full[rd_bank], toggle rd_bank, set rd_cnt to 0, frame_count++.

Per-bank state machine:
- EMPTY → FILLING on the first accepted write.
- FILLING → FULL on the last accepted write.
- FULL → DRAINING on the first accepted read.
- DRAINING → EMPTY on the out_last handshake.
- Only the full flag is architecturally stored. FILLING is implied by wr_cnt ≠ 0 on wr_bank; DRAINING is implied by rd_cnt ≠ 0 on rd_bank.

Boundary rules:
- Set and clear of the same full flag in one cycle cannot occur: set requires !full on wr_bank, clear requires full on rd_bank. An implementation may assert this.
- Write-completion on one bank and read-completion on the other in the same cycle: both take effect.
- Both banks full: in_ready = 0 and in_data is ignored. This is the only input stall condition.
- Both banks empty: out_valid = 0.
- Counters wrap naturally at SAMPLES. frame_count wraps 255 → 0.
- in_valid while in_ready = 0 has no effect. Upstream must hold data, but the sequencer does not check this.
- out_data and out_last must hold stable while out_valid && !out_ready.

## Timing
- Reset values, driven the cycle after rst is sampled high:
  - wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0, full = 00, frame_count = 0
  - outputs: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0
- Bank contents are not reset.
- Reset mid-operation discards any partial or full frames. The first frame after reset starts at index 0 of bank 0.
- Throughput:
  - One sample per cycle in and one per cycle out, sustained, with no bubbles at frame boundaries on either side.
  - Back-to-back frames with out_ready held at 1 stream continuously.
- Latency:
  - out_valid for a frame rises the cycle after the handshake of its last input sample.
  - First out_data is valid in that same cycle (combinational read of a registered bank).
- in_ready falls the cycle after the write that fills the second bank. It rises the cycle after the out_last handshake frees a bank.

## Test plan
- Single frame, SAMPLES=8: in_data 0..7 on consecutive cycles, out_ready=1. out_valid rises at cycle 9. Output is 0,4,2,6,1,5,3,7, out_last is set on 7 only, and frame_count goes to 1.
- Streaming: 4 back-to-back frames (values 8f+i), out_ready=1. in_ready stays 1 throughout, output has no gaps, and each frame is bit-reversed. frame_count = 4 at the end.
- Backpressure: out_ready=0 while 3 frames are offered. in_ready drops after 16 accepted samples, and sample 16 is held off. Then out_ready=1: frames drain in order and the third frame is accepted once bank 0 drains.
- Random out_ready (50%) with random in_valid over 50 frames. Scoreboard confirms every output equals in[bitrev(k)] of its frame, and out_data/out_last stay stable during stalls.
- Reset mid-fill (after 5 samples) and mid-drain (after 3 outputs): outputs return to reset values. The next full frame 0..7 yields 0,4,2,6,1,5,3,7 from bank 0.
- frame_count wrap: 257 frames drained, frame_count = 1.
